// File: rtl/note_player.sv
// note_player
//   Queues up to eight note events and plays them in order as a square wave.
//   Each event holds {octave, note, length}. A note sounds for (L+1)
//   length units, followed by a fixed silent gap. Note code 7 is a rest.
//
// Ports
//   clk          system clock, rising edge
//   rst          synchronous active-high reset
//   stop         synchronous flush: empty queue, abort note, silence
//   in_valid     note event offered this cycle
//   in_octave    octave 0..7 (4 = middle octave)
//   in_note      0..6 = C..B, 7 = rest
//   in_length    length code L, duration (L+1) units
//   in_ready     queue can accept (count < 8 and no stop)
//   buzzer       square-wave speaker drive
//   busy         playing something or queue non-empty
//   cur_octave   octave of the event being played, 0 when idle
//   cur_note     note of the event being played, 0 when idle
//   fifo_count   queued entries, 0..8
//   overflow     one-cycle pulse after an offered event was dropped
module note_player #(
  parameter int unsigned UNIT_CYCLES = 32'd12_500_000,
  parameter int unsigned GAP_CYCLES  = 32'd1_000_000,
  parameter int unsigned DIV_SHIFT   = 32'd0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       stop,
  input  logic       in_valid,
  input  logic [2:0] in_octave,
  input  logic [2:0] in_note,
  input  logic [3:0] in_length,
  output logic       in_ready,
  output logic       buzzer,
  output logic       busy,
  output logic [2:0] cur_octave,
  output logic [2:0] cur_note,
  output logic [3:0] fifo_count,
  output logic       overflow
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_PLAY = 2'd2,
    ST_GAP  = 2'd3
  } state_t;

  // Half-period in clock cycles for a note in a given octave. The table
  // holds octave-4 values at 100 MHz; other octaves halve or double per step.
  function automatic logic [23:0] half_period(input logic [2:0] octave,
                                              input logic [2:0] note);
    logic [23:0] base;
    logic [23:0] scaled;
    case (note)
      3'd0:    base = 24'd191113;
      3'd1:    base = 24'd170265;
      3'd2:    base = 24'd151686;
      3'd3:    base = 24'd143172;
      3'd4:    base = 24'd127551;
      3'd5:    base = 24'd113636;
      3'd6:    base = 24'd101239;
      default: base = 24'd1;  // rest: value unused, buzzer held low
    endcase
    base = base >> DIV_SHIFT;
    if (octave >= 3'd4) begin
      scaled = base >> (octave - 3'd4);
    end else begin
      scaled = base << (3'd4 - octave);
    end
    if (scaled == 24'd0) begin
      half_period = 24'd1;
    end else begin
      half_period = scaled;
    end
  endfunction

  state_t      state_q,    state_d;
  logic [2:0]  wr_ptr_q,   wr_ptr_d;
  logic [2:0]  rd_ptr_q,   rd_ptr_d;
  logic [3:0]  count_q,    count_d;
  logic [2:0]  cur_oct_q,  cur_oct_d;
  logic [2:0]  cur_note_q, cur_note_d;
  logic [23:0] hp_q,       hp_d;
  logic [23:0] hp_cnt_q,   hp_cnt_d;
  logic [31:0] dur_q,      dur_d;
  logic [31:0] gap_q,      gap_d;
  logic        buzzer_q,   buzzer_d;
  logic        busy_q,     busy_d;
  logic        overflow_q, overflow_d;

  logic [9:0]  fifo_mem_q [0:7];
  logic [9:0]  head;
  logic [31:0] len_units;
  logic        ready;
  logic        push;
  logic        pop;

  assign ready = (count_q < 4'd8) & ~stop;
  assign push  = in_valid & ready;
  assign head  = fifo_mem_q[rd_ptr_q];

  // Next-state logic for the playback FSM, queue pointers and tone counters.
  always_comb begin
    state_d    = state_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    cur_oct_d  = cur_oct_q;
    cur_note_d = cur_note_q;
    hp_d       = hp_q;
    hp_cnt_d   = hp_cnt_q;
    dur_d      = dur_q;
    gap_d      = gap_q;
    buzzer_d   = buzzer_q;
    overflow_d = 1'b0;
    pop        = 1'b0;
    len_units  = {28'd0, head[3:0]} + 32'd1;

    if (stop) begin
      // Flush wins over any push offered in the same cycle.
      state_d    = ST_IDLE;
      wr_ptr_d   = 3'd0;
      rd_ptr_d   = 3'd0;
      count_d    = 4'd0;
      cur_oct_d  = 3'd0;
      cur_note_d = 3'd0;
      hp_cnt_d   = 24'd0;
      dur_d      = 32'd0;
      gap_d      = 32'd0;
      buzzer_d   = 1'b0;
    end else begin
      overflow_d = in_valid & ~ready;
      case (state_q)
        ST_IDLE: begin
          if (count_q != 4'd0) begin
            state_d = ST_LOAD;
          end else begin
            state_d = ST_IDLE;
          end
        end
        ST_LOAD: begin
          pop        = 1'b1;
          cur_oct_d  = head[9:7];
          cur_note_d = head[6:4];
          hp_d       = half_period(head[9:7], head[6:4]);
          hp_cnt_d   = 24'd0;
          dur_d      = len_units * UNIT_CYCLES;
          buzzer_d   = 1'b0;
          state_d    = ST_PLAY;
        end
        ST_PLAY: begin
          if (dur_q <= 32'd1) begin
            // Last play cycle: silence and move on to the gap.
            buzzer_d = 1'b0;
            hp_cnt_d = 24'd0;
            dur_d    = 32'd0;
            if (GAP_CYCLES == 32'd0) begin
              state_d    = ST_IDLE;
              cur_oct_d  = 3'd0;
              cur_note_d = 3'd0;
            end else begin
              state_d = ST_GAP;
              gap_d   = GAP_CYCLES;
            end
          end else begin
            dur_d = dur_q - 32'd1;
            if (hp_cnt_q + 24'd1 >= hp_q) begin
              hp_cnt_d = 24'd0;
              if (cur_note_q != 3'd7) begin
                buzzer_d = ~buzzer_q;
              end else begin
                buzzer_d = 1'b0;
              end
            end else begin
              hp_cnt_d = hp_cnt_q + 24'd1;
            end
          end
        end
        ST_GAP: begin
          if (gap_q <= 32'd1) begin
            state_d    = ST_IDLE;
            gap_d      = 32'd0;
            cur_oct_d  = 3'd0;
            cur_note_d = 3'd0;
          end else begin
            gap_d = gap_q - 32'd1;
          end
        end
        default: begin
          state_d = ST_IDLE;
        end
      endcase

      if (push) begin
        wr_ptr_d = wr_ptr_q + 3'd1;
      end else begin
        wr_ptr_d = wr_ptr_q;
      end
      if (pop) begin
        rd_ptr_d = rd_ptr_q + 3'd1;
      end else begin
        rd_ptr_d = rd_ptr_q;
      end
      case ({push, pop})
        2'b10:   count_d = count_q + 4'd1;
        2'b01:   count_d = count_q - 4'd1;
        default: count_d = count_q;
      endcase
    end

    busy_d = (state_d != ST_IDLE) || (count_d != 4'd0);
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      wr_ptr_q   <= 3'd0;
      rd_ptr_q   <= 3'd0;
      count_q    <= 4'd0;
      cur_oct_q  <= 3'd0;
      cur_note_q <= 3'd0;
      hp_q       <= 24'd1;
      hp_cnt_q   <= 24'd0;
      dur_q      <= 32'd0;
      gap_q      <= 32'd0;
      buzzer_q   <= 1'b0;
      busy_q     <= 1'b0;
      overflow_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      cur_oct_q  <= cur_oct_d;
      cur_note_q <= cur_note_d;
      hp_q       <= hp_d;
      hp_cnt_q   <= hp_cnt_d;
      dur_q      <= dur_d;
      gap_q      <= gap_d;
      buzzer_q   <= buzzer_d;
      busy_q     <= busy_d;
      overflow_q <= overflow_d;
    end
  end

  // Queue storage; contents are don't-care until written, so no reset.
  always_ff @(posedge clk) begin
    if (push && !rst) begin
      fifo_mem_q[wr_ptr_q] <= {in_octave, in_note, in_length};
    end
  end

  assign in_ready   = ready;
  assign buzzer     = buzzer_q;
  assign busy       = busy_q;
  assign cur_octave = cur_oct_q;
  assign cur_note   = cur_note_q;
  assign fifo_count = count_q;
  assign overflow   = overflow_q;

endmodule

// File: tb/tb_note_player.sv
// tb_note_player
//   Drives note_player with directed and random note events and compares
//   every output, every cycle, against a timeline model of the player:
//   a queue of pending events plus the elapsed time since the current
//   event was loaded.
module tb_note_player;

  localparam int UNIT   = 500;
  localparam int GAP    = 2;
  localparam int DIV_SH = 10;

  logic       clk;
  logic       rst;
  logic       stop;
  logic       in_valid;
  logic [2:0] in_octave;
  logic [2:0] in_note;
  logic [3:0] in_length;
  logic       in_ready;
  logic       buzzer;
  logic       busy;
  logic [2:0] cur_octave;
  logic [2:0] cur_note;
  logic [3:0] fifo_count;
  logic       overflow;

  note_player #(
    .UNIT_CYCLES(UNIT),
    .GAP_CYCLES (GAP),
    .DIV_SHIFT  (DIV_SH)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .stop      (stop),
    .in_valid  (in_valid),
    .in_octave (in_octave),
    .in_note   (in_note),
    .in_length (in_length),
    .in_ready  (in_ready),
    .buzzer    (buzzer),
    .busy      (busy),
    .cur_octave(cur_octave),
    .cur_note  (cur_note),
    .fifo_count(fifo_count),
    .overflow  (overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;
  int cyc      = 0;

  // Reference model state
  logic [9:0] mq[$];
  bit         m_play = 1'b0;
  int         m_t    = 0;
  int         m_n    = 0;
  int         m_hp   = 1;
  int         m_oct  = 0;
  int         m_note = 0;
  bit         m_ovf  = 1'b0;

  int  toggles   = 0;
  bit  prev_buz  = 1'b0;
  int  max_count = 0;

  int unsigned base_tab [0:6] = '{191113, 170265, 151686, 143172, 127551, 113636, 101239};

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  function automatic int ref_hp(input int oct, input int note);
    longint h;
    if (note > 6) return 1;
    h = longint'(base_tab[note]) >> DIV_SH;
    if (oct >= 4) h = h >> (oct - 4);
    else          h = h << (4 - oct);
    h = h & 64'hFF_FFFF;
    if (h == 0) h = 1;
    return int'(h);
  endfunction

  // One clock cycle: drive inputs, check outputs of this cycle, advance model.
  task automatic step(input logic v, input logic [2:0] o, input logic [2:0] n,
                      input logic [3:0] l, input logic s, input logic r);
    int sz;
    int e_buz;
    int e_oct;
    int e_note;
    in_valid  = v;
    in_octave = o;
    in_note   = n;
    in_length = l;
    stop      = s;
    rst       = r;
    #1;
    if (!r) begin
      e_buz  = 0;
      e_oct  = 0;
      e_note = 0;
      if (m_play && m_t >= 1) begin
        e_oct  = m_oct;
        e_note = m_note;
      end
      if (m_play && m_t >= 1 && m_t <= m_n && m_note != 7)
        e_buz = ((m_t - 1) / m_hp) % 2;
      check_eq("buzzer",     32'(buzzer),     32'(e_buz));
      check_eq("busy",       32'(busy),       32'(m_play || (mq.size() > 0)));
      check_eq("cur_octave", 32'(cur_octave), 32'(e_oct));
      check_eq("cur_note",   32'(cur_note),   32'(e_note));
      check_eq("fifo_count", 32'(fifo_count), 32'(mq.size()));
      check_eq("in_ready",   32'(in_ready),   32'((mq.size() < 8) && !s));
      check_eq("overflow",   32'(overflow),   32'(m_ovf));
      if (buzzer !== prev_buz) toggles++;
      prev_buz = buzzer;
      if (int'(fifo_count) > max_count) max_count = int'(fifo_count);
    end
    // model transition at the coming rising edge
    if (r || s) begin
      mq.delete();
      m_play = 1'b0;
      m_t    = 0;
      m_ovf  = 1'b0;
    end else begin
      sz    = mq.size();
      m_ovf = v && (sz >= 8);
      if (m_play) begin
        if (m_t == 0) void'(mq.pop_front());
        m_t++;
        if (m_t > m_n + GAP) m_play = 1'b0;
      end else if (sz > 0) begin
        m_play = 1'b1;
        m_t    = 0;
        m_oct  = int'(mq[0][9:7]);
        m_note = int'(mq[0][6:4]);
        m_n    = (int'(mq[0][3:0]) + 1) * UNIT;
        m_hp   = ref_hp(m_oct, m_note);
      end
      if (v && sz < 8) mq.push_back({o, n, l});
    end
    @(posedge clk);
    @(negedge clk);
    cyc++;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 3'd0, 3'd0, 4'd0, 1'b0, 1'b0);
  endtask

  // Run until the model has nothing left to play, bounded.
  task automatic drain(input int limit);
    int k;
    k = 0;
    while ((m_play || mq.size() > 0) && k < limit) begin
      idle(1);
      k++;
    end
    idle(2);
    check_eq("drained_busy", 32'(busy), 32'd0);
  endtask

  initial begin
    in_valid  = 1'b0;
    in_octave = 3'd0;
    in_note   = 3'd0;
    in_length = 4'd0;
    stop      = 1'b0;
    rst       = 1'b1;
    @(negedge clk);
    step(1'b0, 3'd0, 3'd0, 4'd0, 1'b0, 1'b1);
    step(1'b0, 3'd0, 3'd0, 4'd0, 1'b0, 1'b1);

    // Idle after reset
    idle(20);

    // Middle-octave A, one unit
    toggles = 0;
    step(1'b1, 3'd4, 3'd5, 4'd0, 1'b0, 1'b0);
    drain(2000);
    check_eq("a4_toggles", 32'(toggles), 32'd4);

    // Octave-5 C, two units
    toggles = 0;
    step(1'b1, 3'd5, 3'd0, 4'd1, 1'b0, 1'b0);
    drain(3000);
    check_eq("c5_toggles", 32'(toggles), 32'd10);

    // Ten back-to-back pushes: one dropped with an overflow pulse
    max_count = 0;
    for (int i = 0; i < 10; i++)
      step(1'b1, 3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)), 4'd0, 1'b0, 1'b0);
    check_eq("burst_max_count", 32'(max_count), 32'd8);
    drain(8000);

    // Stop mid-play with three queued events
    step(1'b1, 3'd4, 3'd0, 4'd3, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) step(1'b1, 3'd4, 3'd2, 4'd0, 1'b0, 1'b0);
    idle(200);
    check_eq("pre_stop_count", 32'(fifo_count), 32'd3);
    step(1'b1, 3'd4, 3'd1, 4'd0, 1'b1, 1'b0);
    check_eq("stop_buzzer", 32'(buzzer),     32'd0);
    check_eq("stop_count",  32'(fifo_count), 32'd0);
    check_eq("stop_busy",   32'(busy),       32'd0);
    check_eq("stop_note",   32'(cur_note),   32'd0);
    idle(5);

    // Rest note stays silent; extreme octaves
    toggles = 0;
    step(1'b1, 3'd3, 3'd7, 4'd0, 1'b0, 1'b0);
    drain(2000);
    check_eq("rest_toggles", 32'(toggles), 32'd0);
    step(1'b1, 3'd7, 3'd6, 4'd0, 1'b0, 1'b0);
    step(1'b1, 3'd0, 3'd0, 4'd0, 1'b0, 1'b0);
    drain(3000);

    // Random traffic with occasional stop and one reset
    for (int i = 0; i < 3000; i++) begin
      step(1'($urandom_range(0, 19) == 0),
           3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)),
           4'($urandom_range(0, 2)),
           1'($urandom_range(0, 399) == 0),
           1'(i == 1700));
    end
    drain(20000);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/note_player.md
NOTE_PLAYER -- requirements
Module: note_player

Interface
REQ-001 Parameter UNIT_CYCLES, default 12_500_000; clock cycles per length unit (125 ms at 100 MHz).
REQ-002 Parameter GAP_CYCLES, default 1_000_000; silent cycles inserted after every note.
REQ-003 Parameter DIV_SHIFT, default 0; right shift applied to half-period table entries (simulation speed-up).
REQ-004 clk  input  1  single system clock; all logic on its rising edge.
REQ-005 rst  input  1  reset, synchronous and active-high.
REQ-006 stop  input  1  synchronous flush: empty queue, abort note, silence.
REQ-007 in_valid  input  1  note event offered.
REQ-008 in_octave  input  3  octave 0..7; 4 = middle octave.
REQ-009 in_note  input  3  0..6 = C,D,E,F,G,A,B; 7 = rest.
REQ-010 in_length  input  4  length code L; duration (L+1) units.
REQ-011 in_ready  output  1  queue can accept (count<8 and stop=0).
REQ-012 buzzer  output  1  square-wave drive to speaker.
REQ-013 busy  output  1  state not IDLE or queue non-empty.
REQ-014 cur_octave / cur_note  output  3/3  event currently playing; 0 when IDLE.
REQ-015 fifo_count  output  4  queued entries, 0..8.
REQ-016 overflow  output  1  one-cycle pulse when in_valid=1, in_ready=0, stop=0.

Function
REQ-017 Event accepted on a rising edge with in_valid=1 and in_ready=1; 8-entry, 10-bit-wide FIFO; in-order playback.
REQ-018 Rejected events are dropped; no back-pressure other than in_ready.
REQ-019 Push and pop in the same cycle: both occur, fifo_count unchanged.
REQ-020 FSM states IDLE, LOAD, PLAY, GAP.
REQ-021 IDLE -> LOAD when registered fifo_count>0; otherwise stay IDLE.
REQ-022 LOAD (one cycle): pop head; register octave, note, length; compute half-period; load duration counter with (L+1)*UNIT_CYCLES; -> PLAY.
REQ-023 Base half-period cycles (octave 4, 100 MHz): C 191113, D 170265, E 151686, F 143172, G 127551, A 113636, B 101239; then >>DIV_SHIFT.
REQ-024 Octave scaling: octave>=4 -> shift right (octave-4); octave<4 -> shift left (4-octave); 24-bit result; result 0 forced to 1.
REQ-025 PLAY: buzzer starts 0 and toggles each time a half-period counter reaches its value (counter then restarts); note 7 holds buzzer 0.
REQ-026 PLAY lasts exactly (L+1)*UNIT_CYCLES cycles -> GAP; buzzer forced 0 on exit.
REQ-027 GAP: buzzer 0 for GAP_CYCLES cycles -> IDLE.
REQ-028 Accept into empty, IDLE block at edge t: LOAD at t+1, PLAY at t+2.
REQ-029 stop=1: next edge FIFO emptied, state IDLE, buzzer 0, cur_* 0, counters cleared; stop has priority over push.
REQ-030 overflow never pulses while stop=1.

Reset
REQ-031 rst=1 at an edge: state IDLE, fifo_count 0, buzzer 0, busy 0, cur_octave 0, cur_note 0, overflow 0, in_ready 1 after release.
REQ-032 rst has priority over stop and in_valid; reset mid-PLAY silences buzzer on that edge.
REQ-033 FIFO storage contents need no reset; only pointers and count are cleared.

Verification (UNIT_CYCLES=500, GAP_CYCLES=2, DIV_SHIFT=10)
REQ-034 Reset, then idle 20 cycles -> buzzer 0, busy 0, fifo_count 0, in_ready 1, overflow 0.
REQ-035 Push octave 4, note 5, L=0 -> PLAY 2 cycles after accept; half-period 110; buzzer toggles at PLAY cycles 110, 220, 330, 440; 0 after 500; busy 0 after GAP.
REQ-036 Push octave 5, note 0, L=1 -> half-period 93 (186>>1); PLAY 1000 cycles; 10 toggles; cur_octave 5, cur_note 0 during PLAY.
REQ-037 10 pushes on consecutive cycles from idle -> first popped at LOAD; fifo_count reaches 8; 10th rejected, overflow pulses once, in_ready 0; 9 notes played in order.
REQ-038 stop asserted mid-PLAY with 3 entries queued -> next edge buzzer 0, fifo_count 0, busy 0, cur_note 0.
REQ-039 Push rest (note 7), L=0 -> buzzer 0 for all 500 PLAY cycles; busy 1 throughout PLAY and GAP.
